// File: rtl/hycube_arb_pkg.sv
// hycube_arb_pkg
// Shared definitions for the router output-port arbiter:
//   - arb_state_e      : arbiter FSM state encoding (IDLE / GRANTED)
//   - MAX_HOLD_DEFAULT : default limit on cycles a contested grant may be held
//   - HOLD_CNT_W       : width of the hold counter (covers MAX_HOLD up to 255)
package hycube_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  localparam int MAX_HOLD_DEFAULT = 4;
  localparam int HOLD_CNT_W       = 8;

endpackage

// File: rtl/encoder_onehot.sv
// encoder_onehot
// Converts a grant vector into a validity flag and a binary index.
// Ports:
//   i__onehot : NUM_BITS-wide vector, expected one-hot or all-zero
//   o__valid  : high iff exactly one bit of i__onehot is set
//   o__index  : binary position of the set bit (don't-care when o__valid low)
module encoder_onehot #(
  parameter int NUM_BITS = 5,
  parameter int LOG_BITS = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic [NUM_BITS-1:0] i__onehot,
  output logic                o__valid,
  output logic [LOG_BITS-1:0] o__index
);

  logic                seen_s;
  logic                multi_s;
  logic [LOG_BITS-1:0] index_s;

  // Scan all bits: note whether any bit is set, whether a second one is set,
  // and OR together the positions (exact for a one-hot input).
  always_comb begin
    seen_s  = 1'b0;
    multi_s = 1'b0;
    index_s = '0;
    for (int k = 0; k < NUM_BITS; k++) begin
      if (i__onehot[k]) begin
        multi_s = multi_s | seen_s;
        seen_s  = 1'b1;
        index_s = index_s | LOG_BITS'(k);
      end else begin
        index_s = index_s;
      end
    end
  end

  assign o__valid = seen_s & ~multi_s;
  assign o__index = index_s;

endmodule

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter
// Round-robin arbiter for one router output port. A grant is held while the
// winner keeps requesting; if it holds for MAX_HOLD cycles while someone else
// waits, it is forcibly released. Every release leaves one zero-grant cycle
// and advances the priority pointer past the released requester.
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   i__request     : level request per requester
//   i__enable      : downstream can accept a new grant
//   o__grant       : registered one-hot / zero grant
//   o__grant_valid : grant is exactly one-hot
//   o__grant_index : binary index of the granted requester
//   o__busy        : arbiter is in the GRANTED state
module rr_hold_arbiter
  import hycube_arb_pkg::*;
#(
  parameter int NUM_REQ     = 5,
  parameter int LOG_NUM_REQ = $clog2(NUM_REQ),
  parameter int MAX_HOLD    = MAX_HOLD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     i__request,
  input  logic                   i__enable,
  output logic [NUM_REQ-1:0]     o__grant,
  output logic                   o__grant_valid,
  output logic [LOG_NUM_REQ-1:0] o__grant_index,
  output logic                   o__busy
);

  localparam logic [HOLD_CNT_W-1:0]  HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD - 1);
  localparam logic [LOG_NUM_REQ:0]   NUM_REQ_W  = (LOG_NUM_REQ + 1)'(NUM_REQ);
  localparam logic [LOG_NUM_REQ-1:0] LAST_IDX   = LOG_NUM_REQ'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [LOG_NUM_REQ-1:0] ptr_q,   ptr_d;
  logic [HOLD_CNT_W-1:0]  hold_q,  hold_d;

  logic [LOG_NUM_REQ:0]   cand_s;
  logic                   pick_found_s;
  logic [NUM_REQ-1:0]     pick_grant_s;
  logic [LOG_NUM_REQ-1:0] next_ptr_s;
  logic                   held_s;
  logic                   other_s;
  logic                   at_limit_s;

  // Rotating-priority search: visit ptr, ptr+1, ... wrapping at NUM_REQ and
  // keep the first requester found. cand_s carries one spare bit so the sum
  // can exceed NUM_REQ-1 before being folded back.
  always_comb begin
    pick_found_s = 1'b0;
    pick_grant_s = '0;
    cand_s       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, ptr_q} + (LOG_NUM_REQ + 1)'(k);
      if (cand_s >= NUM_REQ_W) begin
        cand_s = cand_s - NUM_REQ_W;
      end else begin
        cand_s = cand_s;
      end
      if (!pick_found_s && i__request[cand_s[LOG_NUM_REQ-1:0]]) begin
        pick_found_s = 1'b1;
        pick_grant_s = NUM_REQ'(1'b1) << cand_s[LOG_NUM_REQ-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Release bookkeeping derived from the registered grant.
  assign held_s     = |(grant_q & i__request);
  assign other_s    = |(i__request & ~grant_q);
  assign at_limit_s = (hold_q == HOLD_LIMIT);
  assign next_ptr_s = (o__grant_index == LAST_IDX) ? LOG_NUM_REQ'(1'b0)
                                                   : o__grant_index + LOG_NUM_REQ'(1'b1);

  // Next-state logic. A normal release (request dropped) and a forced release
  // (limit reached with a waiter) share one path, so a coincident drop and
  // force cannot release twice.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ARB_IDLE: begin
        if (i__enable && pick_found_s) begin
          grant_d = pick_grant_s;
          hold_d  = '0;
          state_d = ARB_GRANTED;
        end else begin
          grant_d = '0;
        end
      end
      ARB_GRANTED: begin
        if (!held_s || (at_limit_s && other_s)) begin
          grant_d = '0;
          hold_d  = '0;
          ptr_d   = next_ptr_s;
          state_d = ARB_IDLE;
        end else if (!at_limit_s) begin
          hold_d = hold_q + HOLD_CNT_W'(1'b1);
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State registers; reset clears the grant immediately, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign o__grant = grant_q;
  assign o__busy  = (state_q == ARB_GRANTED);

  encoder_onehot #(
    .NUM_BITS (NUM_REQ),
    .LOG_BITS (LOG_NUM_REQ)
  ) u_encoder_onehot (
    .i__onehot (grant_q),
    .o__valid  (o__grant_valid),
    .o__index  (o__grant_index)
  );

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter
// Directed testbench for rr_hold_arbiter (NUM_REQ=5, MAX_HOLD=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_rr_hold_arbiter;

  logic       clk;
  logic       rst_n;
  logic [4:0] i__request;
  logic       i__enable;
  logic [4:0] o__grant;
  logic       o__grant_valid;
  logic [2:0] o__grant_index;
  logic       o__busy;

  int         vectors;
  int         miscompares;
  logic [4:0] exp_g;
  logic [2:0] exp_i;

  rr_hold_arbiter #(
    .NUM_REQ  (5),
    .MAX_HOLD (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i__request     (i__request),
    .i__enable      (i__enable),
    .o__grant       (o__grant),
    .o__grant_valid (o__grant_valid),
    .o__grant_index (o__grant_index),
    .o__busy        (o__busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_arb(input string tag, input logic [4:0] eg, input logic [2:0] ei,
                         input logic eb);
    chk({tag, ".grant"}, 32'(o__grant), 32'(eg));
    chk({tag, ".valid"}, 32'(o__grant_valid), 32'(eg != 5'b00000));
    if (eg != 5'b00000) chk({tag, ".index"}, 32'(o__grant_index), 32'(ei));
    chk({tag, ".busy"}, 32'(o__busy), 32'(eb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    i__request = 5'b00000;
    i__enable  = 1'b0;
    #2;
    chk_arb("reset", 5'b00000, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    i__request  = 5'b00000;
    i__enable   = 1'b0;
    #1;
    do_reset();

    // Single request: granted one edge later, not combinationally.
    i__request = 5'b00100;
    i__enable  = 1'b1;
    #1;
    chk_arb("single.latency", 5'b00000, 3'd0, 1'b0);
    tick();
    chk_arb("single.grant", 5'b00100, 3'd2, 1'b1);

    // Two requesters alternating 0,4,0,4 with one gap cycle after each release.
    do_reset();
    i__enable = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp_g = (r % 2 == 0) ? 5'b00001 : 5'b10000;
      exp_i = (r % 2 == 0) ? 3'd0 : 3'd4;
      i__request = 5'b10001;
      tick();
      chk_arb("alt.grant", exp_g, exp_i, 1'b1);
      tick();
      chk_arb("alt.hold", exp_g, exp_i, 1'b1);
      i__request = 5'b10001 & ~exp_g;
      tick();
      chk_arb("alt.gap", 5'b00000, 3'd0, 1'b0);
    end

    // Forced release: index 1 held 4 grant cycles while index 3 waits.
    do_reset();
    i__enable  = 1'b1;
    i__request = 5'b00010;
    tick();
    chk_arb("force.c1", 5'b00010, 3'd1, 1'b1);
    i__request = 5'b01010;
    tick();
    chk_arb("force.c2", 5'b00010, 3'd1, 1'b1);
    tick();
    chk_arb("force.c3", 5'b00010, 3'd1, 1'b1);
    tick();
    chk_arb("force.c4", 5'b00010, 3'd1, 1'b1);
    tick();
    chk_arb("force.release", 5'b00000, 3'd0, 1'b0);
    tick();
    chk_arb("force.next", 5'b01000, 3'd3, 1'b1);
    // Index 1 (still requesting) only comes back through the rotation.
    i__request = 5'b00010;
    tick();
    chk_arb("force.rot_gap", 5'b00000, 3'd0, 1'b0);
    tick();
    chk_arb("force.rot_regrant", 5'b00010, 3'd1, 1'b1);

    // Drop of the granted request coinciding with a forced release.
    do_reset();
    i__enable  = 1'b1;
    i__request = 5'b00010;
    tick();
    i__request = 5'b01010;
    tick();
    tick();
    tick();
    chk_arb("coinc.pre", 5'b00010, 3'd1, 1'b1);
    i__request = 5'b01000;
    tick();
    chk_arb("coinc.release", 5'b00000, 3'd0, 1'b0);
    tick();
    chk_arb("coinc.next", 5'b01000, 3'd3, 1'b1);

    // Lone holder keeps the grant; saturated counter forces release at once.
    do_reset();
    i__enable  = 1'b1;
    i__request = 5'b00010;
    tick();
    chk_arb("sat.grant", 5'b00010, 3'd1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_arb("sat.hold", 5'b00010, 3'd1, 1'b1);
    end
    i__request = 5'b00011;
    tick();
    chk_arb("sat.release", 5'b00000, 3'd0, 1'b0);
    tick();
    chk_arb("sat.wrapgrant", 5'b00001, 3'd0, 1'b1);

    // Enable gating in IDLE; enable ignored while GRANTED.
    do_reset();
    i__request = 5'b11111;
    i__enable  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_arb("en.blocked", 5'b00000, 3'd0, 1'b0);
    end
    i__enable = 1'b1;
    tick();
    chk_arb("en.grant", 5'b00001, 3'd0, 1'b1);
    i__enable = 1'b0;
    tick();
    chk_arb("en.held", 5'b00001, 3'd0, 1'b1);
    i__request = 5'b11110;
    tick();
    chk_arb("en.release", 5'b00000, 3'd0, 1'b0);
    i__request = 5'b11111;
    i__enable  = 1'b1;
    tick();
    chk_arb("en.rotate", 5'b00010, 3'd1, 1'b1);

    // Asynchronous reset mid-grant clears outputs before any edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_arb("async.reset", 5'b00000, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_arb("async.ptr0", 5'b00001, 3'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
